// File: rtl/ext_pkg.sv
// Mode encoding and the shared extend/align function used by extend_unit_pipe.
// The function works on a MAX_W-wide word so one body serves every DATA_W/IMM_W.
package ext_pkg;

   localparam int MAX_W = 64;
   localparam logic [MAX_W-1:0] ONE = MAX_W'(1);

   typedef enum logic [2:0] {
      EXT_SE   = 3'b000,
      EXT_ZE   = 3'b001,
      EXT_LUI  = 3'b010,
      EXT_LUI2 = 3'b011,
      EXT_LB   = 3'b100,
      EXT_LBU  = 3'b101,
      EXT_LH   = 3'b110,
      EXT_LHU  = 3'b111
   } ext_mode_e;

   typedef struct packed {
      logic             misal;
      logic [MAX_W-1:0] data;
   } ext_res_t;

   function automatic ext_res_t ext_compute(input ext_mode_e        mode,
                                            input logic [MAX_W-1:0] word,
                                            input logic [5:0]       off,
                                            input int               data_w,
                                            input int               imm_w);
      ext_res_t         r;
      logic [MAX_W-1:0] shifted;
      logic [MAX_W-1:0] imm_mask;
      logic [MAX_W-1:0] field;
      logic [MAX_W-1:0] ext_mask;
      logic             sgn;
      logic             msb;
      int               fw;

      r        = '0;
      shifted  = word >> (int'(off) * 8);
      imm_mask = (ONE << imm_w) - ONE;
      field    = '0;
      fw       = imm_w;
      sgn      = 1'b0;

      case (mode)
         EXT_SE, EXT_ZE: begin
            field = word & imm_mask;
            sgn   = (mode == EXT_SE);
         end
         EXT_LUI, EXT_LUI2: begin
            field = (word & imm_mask) << imm_w;
            fw    = 2 * imm_w;
            sgn   = 1'b1;
         end
         EXT_LB, EXT_LBU: begin
            field = shifted & MAX_W'(8'hff);
            fw    = 8;
            sgn   = (mode == EXT_LB);
         end
         default: begin
            // An odd offset, or a half that would run past the word, yields a
            // flagged zero result rather than a partial half.
            r.misal = off[0] || ((int'(off) * 8 + 16) > data_w);
            field   = r.misal ? '0 : (shifted & MAX_W'(16'hffff));
            fw      = 16;
            sgn     = (mode == EXT_LH);
         end
      endcase

      msb      = |(field & (ONE << (fw - 1)));
      ext_mask = (ONE << fw) - ONE;
      r.data   = (sgn && msb) ? (field | ~ext_mask) : field;
      r.data   = r.data & ((ONE << data_w) - ONE);
      return r;
   endfunction

endpackage

// File: rtl/ext_result_fifo.sv
// DEPTH-entry result queue holding {misal, tag, data}; head is always visible
// on rdata, pointers wrap naturally because DEPTH is a power of two.
module ext_result_fifo #(
   parameter int W     = 38,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the storage is reset too, because rdata is the output
         // register view and must read zero straight out of reset.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/extend_unit_pipe.sv
// Registered extend/align unit: immediate SE/ZE/LUI and load byte/half
// extraction, buffered in a small FIFO so writeback can stall.
module extend_unit_pipe
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int TAG_W  = 5,
   parameter int DEPTH  = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [2:0]                  in_mode,
   input  logic [DATA_W-1:0]           in_data,
   input  logic [$clog2(DATA_W/8)-1:0] in_off,
   input  logic [TAG_W-1:0]            in_tag,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic [TAG_W-1:0]            out_tag,
   output logic                        out_misal,
   output logic [$clog2(DEPTH):0]      out_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int ENT_W = 1 + TAG_W + DATA_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [MAX_W-1:0] word;
   ext_res_t         res;
   logic             push;
   logic             pop;

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      word             = '0;
      word[DATA_W-1:0] = in_data;
      res              = ext_compute(ext_mode_e'(in_mode), word, 6'(in_off), DATA_W, IMM_W);
   end

   // A full buffer still accepts when the head leaves in the same cycle.
   assign in_ready  = (out_count != FULL_CNT) || out_ready;
   assign out_valid = (out_count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   if (DATA_W < MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = |res.data[MAX_W-1:DATA_W];
   end

   ext_result_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({res.misal, in_tag, res.data[DATA_W-1:0]}),
      .rdata ({out_misal, out_tag, out_data}),
      .count (out_count)
   );

endmodule

// File: tb/tb_extend_unit_pipe.sv
// Self-checking bench for extend_unit_pipe: directed spec vectors, backpressure,
// mid-stream reset and a randomized run against a queue-based reference model.
module tb_extend_unit_pipe;

   localparam int DATA_W = 32;
   localparam int IMM_W  = 16;
   localparam int TAG_W  = 5;
   localparam int DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_mode;
   logic [31:0] in_data;
   logic [1:0]  in_off;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;
   logic        out_misal;
   logic [1:0]  out_count;

   extend_unit_pipe #(
      .DATA_W (DATA_W),
      .IMM_W  (IMM_W),
      .TAG_W  (TAG_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .in_off    (in_off),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_misal (out_misal),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
      logic        misal;
   } res_t;

   res_t exp_q[$];

   // Handshake outcome of the last step, sampled at the negedge before the edge.
   logic        acc, popd, seen_ready, seen_valid, seen_misal;
   logic [1:0]  seen_count;
   logic [31:0] seen_data;
   logic [4:0]  seen_tag;
   int          pre_size;

   // Reference: plain arithmetic on the instruction semantics.
   function automatic res_t model(input logic [2:0] mode, input logic [31:0] d,
                                  input int off, input logic [4:0] tag);
      res_t   r;
      longint v;
      longint imm;
      longint lane;
      r.tag   = tag;
      r.misal = 1'b0;
      v       = 0;
      imm     = longint'(d) % 65536;
      case (mode)
         3'd0: v = (imm >= 32768) ? imm - 65536 : imm;
         3'd1: v = imm;
         3'd2, 3'd3: v = imm * 65536;
         3'd4, 3'd5: begin
            lane = (longint'(d) / (longint'(1) << (8 * off))) % 256;
            v    = (mode == 3'd4 && lane >= 128) ? lane - 256 : lane;
         end
         default: begin
            if (off % 2 == 1 || 8 * off + 16 > 32) r.misal = 1'b1;
            else begin
               lane = (longint'(d) / (longint'(1) << (8 * off))) % 65536;
               v    = (mode == 3'd6 && lane >= 32768) ? lane - 65536 : lane;
            end
         end
      endcase
      r.data = 32'(v);
      return r;
   endfunction

   task automatic step(input logic v, input logic [2:0] m, input logic [31:0] d,
                       input logic [1:0] off, input logic [4:0] tag, input logic ordy);
      @(negedge clk);
      in_valid  = v;
      in_mode   = m;
      in_data   = d;
      in_off    = off;
      in_tag    = tag;
      out_ready = ordy;
      #1;
      acc        = in_valid && in_ready;
      popd       = out_valid && out_ready;
      seen_ready = in_ready;
      seen_valid = out_valid;
      seen_count = out_count;
      seen_data  = out_data;
      seen_tag   = out_tag;
      seen_misal = out_misal;
      pre_size   = exp_q.size();
      if (acc) exp_q.push_back(model(m, d, int'(off), tag));
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mode   = '0;
      in_data   = '0;
      in_off    = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_count !== 2'd0 || out_data !== 32'h0 ||
          out_tag !== 5'h0 || out_misal !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b count=%0d data=%h tag=%h misal=%b, want 0/0/0/0/0",
                  out_valid, out_count, out_data, out_tag, out_misal);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      exp_q.delete();
   endtask

   task automatic test_imm();
      logic [2:0]  m[3] = '{3'd0, 3'd1, 3'd2};
      logic [31:0] d[3] = '{32'hABCD_8001, 32'h5555_8001, 32'h0000_1234};
      logic [31:0] e[3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h1234_0000};
      for (int i = 0; i < 4; i++) begin
         if (i < 3) step(1'b1, m[i], d[i], 2'd0, 5'(i + 1), 1'b1);
         else       step(1'b0, 3'd0, 32'h0, 2'd0, 5'd0, 1'b1);
         if (i > 0) begin
            checks++;
            if (!popd || seen_data !== e[i-1] || seen_tag !== 5'(i) || seen_misal !== 1'b0) begin
               errors++;
               $display("FAIL imm_%0d: valid=%b data=%h tag=%0d misal=%b, want 1/%h/%0d/0",
                        i - 1, seen_valid, seen_data, seen_tag, seen_misal, e[i-1], i);
            end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_load();
      logic [2:0]  m[7]   = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7};
      logic [1:0]  o[7]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1};
      logic [31:0] e[7]   = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                              32'h0000_0080, 32'hFFFF_80FF, 32'h0000_0000};
      logic        mis[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         if (i < 7) step(1'b1, m[i], 32'h80FF_7F01, o[i], 5'(i + 8), 1'b1);
         else       step(1'b0, 3'd0, 32'h0, 2'd0, 5'd0, 1'b1);
         if (i > 0) begin
            checks++;
            if (!popd || seen_data !== e[i-1] || seen_tag !== 5'(i + 7) || seen_misal !== mis[i-1]) begin
               errors++;
               $display("FAIL load_%0d: valid=%b data=%h tag=%0d misal=%b, want 1/%h/%0d/%b",
                        i - 1, seen_valid, seen_data, seen_tag, seen_misal, e[i-1], i + 7, mis[i-1]);
            end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      res_t e;
      exp_q.delete();
      step(1'b1, 3'd4, 32'h1122_3344, 2'd0, 5'd1, 1'b0);
      step(1'b1, 3'd5, 32'h1122_3344, 2'd1, 5'd2, 1'b0);
      step(1'b1, 3'd6, 32'h1122_3344, 2'd2, 5'd3, 1'b0);
      checks++;
      if (seen_ready !== 1'b0 || acc !== 1'b0 || seen_count !== 2'd2) begin
         errors++;
         $display("FAIL bp_full: in_ready=%b acc=%b count=%0d, want 0/0/2", seen_ready, acc, seen_count);
      end
      // Third request held unchanged; releasing out_ready lets it in alongside a pop.
      step(1'b1, 3'd6, 32'h1122_3344, 2'd2, 5'd3, 1'b1);
      checks++;
      if (seen_ready !== 1'b1 || acc !== 1'b1 || seen_count !== 2'd2) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b acc=%b count=%0d, want 1/1/2", seen_ready, acc, seen_count);
      end
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step(1'b0, 3'd0, 32'h0, 2'd0, 5'd0, 1'b1);
         checks++;
         if (!popd || exp_q.size() == 0) begin
            errors++;
            $display("FAIL bp_pop_%0d: popped=%b, want 1", i, popd);
         end else begin
            e = exp_q.pop_front();
            if (seen_data !== e.data || seen_tag !== e.tag || seen_misal !== e.misal) begin
               errors++;
               $display("FAIL bp_order_%0d: data=%h tag=%0d misal=%b, want %h/%0d/%b",
                        i, seen_data, seen_tag, seen_misal, e.data, e.tag, e.misal);
            end
         end
      end
      step(1'b0, 3'd0, 32'h0, 2'd0, 5'd0, 1'b1);
      checks++;
      if (seen_valid !== 1'b0 || seen_count !== 2'd0) begin
         errors++;
         $display("FAIL bp_empty: valid=%b count=%0d, want 0/0", seen_valid, seen_count);
      end
   endtask

   task automatic test_full_passthrough();
      res_t e;
      exp_q.delete();
      step(1'b1, 3'd0, 32'h0000_F00D, 2'd0, 5'd10, 1'b0);
      step(1'b1, 3'd1, 32'h0000_BEEF, 2'd0, 5'd11, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) step(1'b1, 3'(i + 4), 32'hC3A5_7E18, 2'(i * 2), 5'(12 + i), 1'b1);
         else       step(1'b0, 3'd0, 32'h0, 2'd0, 5'd0, 1'b1);
         if (i < 4) begin
            checks++;
            if (acc !== 1'b1 || seen_count !== 2'd2) begin
               errors++;
               $display("FAIL pass_count_%0d: acc=%b count=%0d, want 1/2", i, acc, seen_count);
            end
         end
         checks++;
         if (!popd || exp_q.size() == 0) begin
            errors++;
            $display("FAIL pass_pop_%0d: popped=%b, want 1", i, popd);
         end else begin
            e = exp_q.pop_front();
            if (seen_data !== e.data || seen_tag !== e.tag || seen_misal !== e.misal) begin
               errors++;
               $display("FAIL pass_data_%0d: data=%h tag=%0d misal=%b, want %h/%0d/%b",
                        i, seen_data, seen_tag, seen_misal, e.data, e.tag, e.misal);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      res_t e;
      exp_q.delete();
      step(1'b1, 3'd0, 32'h0000_7FFF, 2'd0, 5'd20, 1'b0);
      step(1'b1, 3'd1, 32'h0000_FFFF, 2'd0, 5'd21, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_count !== 2'd0 || out_data !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset: valid=%b count=%0d data=%h, want 0/0/0", out_valid, out_count, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      step(1'b1, 3'd2, 32'h0000_8765, 2'd0, 5'd22, 1'b1);
      checks++;
      if (acc !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_push: acc=%b, want 1", acc);
      end
      step(1'b0, 3'd0, 32'h0, 2'd0, 5'd0, 1'b1);
      checks++;
      if (!popd || exp_q.size() == 0) begin
         errors++;
         $display("FAIL mid_reset_pop: popped=%b, want 1", popd);
      end else begin
         e = exp_q.pop_front();
         if (seen_data !== e.data || seen_tag !== e.tag || seen_count !== 2'd1) begin
            errors++;
            $display("FAIL mid_reset_data: data=%h tag=%0d count=%0d, want %h/%0d/1",
                     seen_data, seen_tag, seen_count, e.data, e.tag);
         end
      end
   endtask

   task automatic test_random();
      res_t        e;
      logic        v       = 1'b0;
      logic        ordy;
      logic        pending = 1'b0;
      logic [2:0]  m       = '0;
      logic [31:0] d       = '0;
      logic [1:0]  off     = '0;
      logic [4:0]  tag     = '0;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         if (!pending) begin
            v   = ($urandom_range(0, 3) != 0);
            m   = 3'($urandom);
            d   = $urandom;
            off = 2'($urandom);
            tag = 5'($urandom);
         end
         ordy = ($urandom_range(0, 2) != 0);
         step(v, m, d, off, tag, ordy);
         pending = v && !acc;
         checks++;
         if (int'(seen_count) != pre_size || seen_valid !== (pre_size != 0)) begin
            errors++;
            $display("FAIL rnd_count_%0d: count=%0d valid=%b, want %0d/%b",
                     c, seen_count, seen_valid, pre_size, pre_size != 0);
         end
         if (popd) begin
            checks++;
            e = exp_q.pop_front();
            if (seen_data !== e.data || seen_tag !== e.tag || seen_misal !== e.misal) begin
               errors++;
               $display("FAIL rnd_data_%0d: data=%h tag=%0d misal=%b, want %h/%0d/%b",
                        c, seen_data, seen_tag, seen_misal, e.data, e.tag, e.misal);
            end
         end
      end
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         step(1'b0, 3'd0, 32'h0, 2'd0, 5'd0, 1'b1);
         if (popd) begin
            checks++;
            e = exp_q.pop_front();
            if (seen_data !== e.data || seen_tag !== e.tag || seen_misal !== e.misal) begin
               errors++;
               $display("FAIL rnd_drain: data=%h tag=%0d misal=%b, want %h/%0d/%b",
                        seen_data, seen_tag, seen_misal, e.data, e.tag, e.misal);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rnd_drain_left: %0d results never appeared, want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_imm();
      test_load();
      test_backpressure();
      test_full_passthrough();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
